// File: rtl/mul_arbiter.sv
// Purpose: round-robin arbiter sharing one 16-bit multiplier among N_REQ requesters.
// Latency: k+3 cycles from the IDLE sampling edge to out_Done (k = WAIT cycles up to the ready edge).
// Backpressure: one transaction at a time; requests are only sampled in IDLE, others simply wait.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   in_Req[N_REQ]              per-requester request level
//   in_A/in_B[16*N_REQ]        packed operands, requester i at [16i+15:16i]
//   out_Grant/out_Done[N_REQ]  one-hot owner / one-cycle completion pulse
//   out_Result[16]             latest product (0 after a timeout)
//   out_MulA/B, out_MulEn      operands and start strobe to the multiplier
//   in_MulOut, in_MulReady     product and product-valid from the multiplier
//   out_Busy, out_Err          FSM not idle / sticky timeout flag
module mul_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     in_Req,
  input  logic [16*N_REQ-1:0]  in_A,
  input  logic [16*N_REQ-1:0]  in_B,
  output logic [N_REQ-1:0]     out_Grant,
  output logic [N_REQ-1:0]     out_Done,
  output logic [15:0]          out_Result,
  output logic [15:0]          out_MulA,
  output logic [15:0]          out_MulB,
  output logic                 out_MulEn,
  input  logic [15:0]          in_MulOut,
  input  logic                 in_MulReady,
  output logic                 out_Busy,
  output logic                 out_Err
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   win;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   pick;
  logic [15:0]     a_arr [N_REQ];
  logic [15:0]     b_arr [N_REQ];

  // Unpack the operand buses so the winner can be selected by index.
  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign a_arr[g] = in_A[16*g +: 16];
    assign b_arr[g] = in_B[16*g +: 16];
  end

  // First requester at or after p, wrapping modulo N_REQ. The result is
  // only used when at least one request is pending.
  function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                            input logic [IW-1:0]    p);
    logic [IW-1:0] idx;
    logic [IW-1:0] res;
    logic          found;
    idx   = p;
    res   = p;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req[idx]) begin
        res   = idx;
        found = 1'b1;
      end
      idx = (idx == IW'(N_REQ - 1)) ? '0 : idx + 1'b1;
    end
    return res;
  endfunction

  always_comb begin
    pick = rr_pick(in_Req, ptr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      win        <= '0;
      cnt        <= '0;
      out_Grant  <= '0;
      out_Done   <= '0;
      out_Result <= '0;
      out_MulA   <= '0;
      out_MulB   <= '0;
      out_MulEn  <= 1'b0;
      out_Busy   <= 1'b0;
      out_Err    <= 1'b0;
    end else begin
      // Strobes default low so each is exactly one cycle wide.
      out_Done  <= '0;
      out_MulEn <= 1'b0;
      case (state)
        IDLE: begin
          if (|in_Req) begin
            win       <= pick;
            out_MulA  <= a_arr[pick];
            out_MulB  <= b_arr[pick];
            out_Grant <= {{(N_REQ-1){1'b0}}, 1'b1} << pick;
            out_MulEn <= 1'b1;
            out_Busy  <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // Ready wins over a timeout landing on the same edge.
          if (in_MulReady) begin
            out_Result <= in_MulOut;
            out_Done   <= out_Grant;
            state      <= DONE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            out_Err    <= 1'b1;
            out_Result <= 16'h0000;
            out_Done   <= out_Grant;
            state      <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          // The just-served requester drops to lowest priority.
          ptr       <= (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
          cnt       <= '0;
          out_Grant <= '0;
          out_Busy  <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Purpose: directed self-checking bench for mul_arbiter (N_REQ=4, TIMEOUT=16).
// Latency: inputs change 1 time unit after a rising edge, outputs are sampled there too.
// Backpressure: the bench plays the multiplier, asserting in_MulReady on chosen WAIT cycles.
module tb_mul_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  in_Req = '0;
  logic [63:0] in_A = '0;
  logic [63:0] in_B = '0;
  logic [3:0]  out_Grant;
  logic [3:0]  out_Done;
  logic [15:0] out_Result;
  logic [15:0] out_MulA;
  logic [15:0] out_MulB;
  logic        out_MulEn;
  logic [15:0] in_MulOut = '0;
  logic        in_MulReady = 1'b0;
  logic        out_Busy;
  logic        out_Err;

  int checks = 0;
  int failures = 0;

  mul_arbiter #(.N_REQ(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .in_Req(in_Req), .in_A(in_A), .in_B(in_B),
    .out_Grant(out_Grant), .out_Done(out_Done), .out_Result(out_Result),
    .out_MulA(out_MulA), .out_MulB(out_MulB), .out_MulEn(out_MulEn),
    .in_MulOut(in_MulOut), .in_MulReady(in_MulReady),
    .out_Busy(out_Busy), .out_Err(out_Err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".grant"},  32'(out_Grant),  0);
    chk({tag, ".done"},   32'(out_Done),   0);
    chk({tag, ".result"}, 32'(out_Result), 0);
    chk({tag, ".mula"},   32'(out_MulA),   0);
    chk({tag, ".mulb"},   32'(out_MulB),   0);
    chk({tag, ".mulen"},  32'(out_MulEn),  0);
    chk({tag, ".busy"},   32'(out_Busy),   0);
    chk({tag, ".err"},    32'(out_Err),    0);
  endtask

  // Called one step after the edge that entered ISSUE; returns one step
  // after the edge that re-entered IDLE. Ready is given on WAIT cycle k.
  task automatic serve(input string tag, input int k, input logic [15:0] prod,
                       input logic [3:0] g, input logic [15:0] ea, input logic [15:0] eb);
    chk({tag, ".issue_grant"}, 32'(out_Grant), 32'(g));
    chk({tag, ".issue_mulen"}, 32'(out_MulEn), 1);
    chk({tag, ".issue_mula"},  32'(out_MulA),  32'(ea));
    chk({tag, ".issue_mulb"},  32'(out_MulB),  32'(eb));
    chk({tag, ".issue_busy"},  32'(out_Busy),  1);
    tick();
    chk({tag, ".wait_mulen"},  32'(out_MulEn), 0);
    for (int c = 1; c < k; c++) begin
      chk({tag, ".wait_done"}, 32'(out_Done), 0);
      tick();
    end
    in_MulReady = 1'b1;
    in_MulOut   = prod;
    tick();
    in_MulReady = 1'b0;
    in_MulOut   = 16'h0000;
    chk({tag, ".done"},        32'(out_Done),   32'(g));
    chk({tag, ".done_result"}, 32'(out_Result), 32'(prod));
    chk({tag, ".done_grant"},  32'(out_Grant),  32'(g));
    chk({tag, ".done_mula"},   32'(out_MulA),   32'(ea));
    tick();
    chk({tag, ".idle_done"},   32'(out_Done),  0);
    chk({tag, ".idle_grant"},  32'(out_Grant), 0);
    chk({tag, ".idle_busy"},   32'(out_Busy),  0);
    chk({tag, ".idle_result"}, 32'(out_Result), 32'(prod));
  endtask

  initial begin
    // Reset held across several edges: everything zero.
    #1;
    chk_zero("rst_async");
    tick(); tick(); tick();
    chk_zero("rst_held");
    rst = 1'b0;
    tick();
    chk_zero("idle_noreq");

    // All four pending, held: served 0,1,2,3,0 from ptr=0.
    in_A   = {16'h0013, 16'h0012, 16'h0011, 16'h0010};
    in_B   = {16'h0023, 16'h0022, 16'h0021, 16'h0020};
    in_Req = 4'b1111;
    tick(); serve("rr0", 1, 16'h0A00, 4'b0001, 16'h0010, 16'h0020);
    tick(); serve("rr1", 2, 16'h0A01, 4'b0010, 16'h0011, 16'h0021);
    tick(); serve("rr2", 1, 16'h0A02, 4'b0100, 16'h0012, 16'h0022);
    tick(); serve("rr3", 3, 16'h0A03, 4'b1000, 16'h0013, 16'h0023);
    tick(); serve("rr4", 1, 16'h0A04, 4'b0001, 16'h0010, 16'h0020);
    in_Req = 4'b0000;
    tick();
    chk("rr_idle_mulen", 32'(out_MulEn), 0);
    chk("rr_idle_busy",  32'(out_Busy),  0);

    // Single request, product after 2 WAIT cycles; request dropped after
    // the grant and operand A changed mid-WAIT. ptr=1 here.
    in_A   = {48'h0, 16'h1000};
    in_B   = {48'h0, 16'h1000};
    in_Req = 4'b0001;
    tick();                                   // sampling edge -> ISSUE
    chk("single.grant", 32'(out_Grant), 32'h1);
    chk("single.mulen", 32'(out_MulEn), 1);
    chk("single.mula",  32'(out_MulA),  32'h1000);
    chk("single.mulb",  32'(out_MulB),  32'h1000);
    in_Req = 4'b0000;
    tick();                                   // WAIT cycle 1
    chk("single.wait_mulen", 32'(out_MulEn), 0);
    chk("single.wait_grant", 32'(out_Grant), 32'h1);
    in_A = {48'h0, 16'hBEEF};
    tick();                                   // WAIT cycle 2
    chk("single.wait2_done", 32'(out_Done), 0);
    chk("single.wait2_mula", 32'(out_MulA), 32'h1000);
    in_MulReady = 1'b1;
    in_MulOut   = 16'h0100;
    tick();                                   // DONE: 5th cycle counting the IDLE one
    in_MulReady = 1'b0;
    in_MulOut   = 16'h0000;
    chk("single.done",        32'(out_Done),   32'h1);
    chk("single.done_result", 32'(out_Result), 32'h0100);
    chk("single.done_mula",   32'(out_MulA),   32'h1000);
    tick();
    chk("single.idle_done",   32'(out_Done),   0);
    chk("single.idle_result", 32'(out_Result), 32'h0100);

    // Timeout: ready never comes. ptr=1.
    in_A   = {16'h0, 16'h5555, 32'h0};
    in_B   = {16'h0, 16'h6666, 32'h0};
    in_Req = 4'b0100;
    tick();
    chk("to.grant", 32'(out_Grant), 32'h4);
    in_Req = 4'b0000;
    tick();                                   // WAIT cycle 1
    for (int c = 1; c < 16; c++) tick();      // WAIT cycle 16
    chk("to.wait16_done", 32'(out_Done), 0);
    chk("to.wait16_err",  32'(out_Err),  0);
    chk("to.wait16_busy", 32'(out_Busy), 1);
    tick();
    chk("to.done",        32'(out_Done),   32'h4);
    chk("to.done_result", 32'(out_Result), 0);
    chk("to.done_err",    32'(out_Err),    1);
    tick();
    chk("to.idle_err",    32'(out_Err),    1);

    // Err stays set across a good transaction. ptr=3.
    in_A   = 64'h4444_3333_2222_1111;
    in_B   = 64'h8888_7777_6666_5555;
    in_Req = 4'b1000;
    tick();
    in_Req = 4'b0000;
    serve("sticky", 1, 16'h1234, 4'b1000, 16'h4444, 16'h8888);
    chk("sticky.err", 32'(out_Err), 1);

    // Reset mid-WAIT: outputs drop at once, no done pulse, ptr back to 0.
    in_Req = 4'b0100;
    tick(); tick(); tick();                   // WAIT cycle 2
    chk("midrst.pre_busy", 32'(out_Busy), 1);
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    in_Req = 4'b1010;
    tick();
    chk("midrst.held_done", 32'(out_Done), 0);
    chk("midrst.held_err",  32'(out_Err),  0);
    rst = 1'b0;
    tick();
    serve("post_rst1", 1, 16'h0055, 4'b0010, 16'h2222, 16'h6666);

    // Ready on the same edge the counter reaches TIMEOUT.
    tick();
    in_Req = 4'b0000;
    serve("edge16", 16, 16'h7FFF, 4'b1000, 16'h4444, 16'h8888);
    chk("edge16.err", 32'(out_Err), 0);

    // Ready outside WAIT is ignored.
    in_MulReady = 1'b1;
    in_MulOut   = 16'hDEAD;
    tick(); tick();
    in_MulReady = 1'b0;
    chk("idle_ready.result", 32'(out_Result), 32'h7FFF);
    chk("idle_ready.done",   32'(out_Done),   0);
    chk("idle_ready.busy",   32'(out_Busy),   0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 SHALL provide parameter N_REQ, default 4, meaning the number of requesters sharing one multiplier (2..8).
REQ-002 SHALL provide parameter TIMEOUT, default 16, meaning the maximum number of WAIT cycles allowed for in_MulReady.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port in_Req  input  N_REQ  per-requester request level.
REQ-006 SHALL have port in_A  input  16*N_REQ  operand A per requester; requester i occupies bits [16i+15:16i].
REQ-007 SHALL have port in_B  input  16*N_REQ  operand B per requester, packed the same way as in_A.
REQ-008 SHALL have port out_Grant  output  N_REQ  one-hot owner of the multiplier.
REQ-009 SHALL have port out_Done  output  N_REQ  one-hot, one-cycle completion pulse.
REQ-010 SHALL have port out_Result  output  16  latest product.
REQ-011 SHALL have port out_MulA / out_MulB  output  16 each  operands to the multiplier.
REQ-012 SHALL have port out_MulEn  output  1  multiplier start strobe.
REQ-013 SHALL have port in_MulOut  input  16  multiplier product.
REQ-014 SHALL have port in_MulReady  input  1  multiplier product valid.
REQ-015 SHALL have port out_Busy  output  1  high whenever the FSM state is not IDLE.
REQ-016 SHALL have port out_Err  output  1  sticky timeout flag.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT and DONE.
REQ-018 In IDLE with any in_Req bit set, the block SHALL, at the clock edge, select the winner by round-robin search starting at pointer ptr and wrapping modulo N_REQ; latch the winner's index, in_A and in_B; and move to ISSUE.
REQ-019 In IDLE with no in_Req bit set, the block SHALL remain in IDLE with out_MulEn=0.
REQ-020 In ISSUE, the block SHALL drive out_MulEn=1 for exactly one cycle with the latched operands on out_MulA/out_MulB, then move to WAIT.
REQ-021 out_MulA/out_MulB SHALL hold the latched operands from ISSUE through DONE; later changes on in_A/in_B SHALL have no effect.
REQ-022 out_Grant SHALL be one-hot on the winner from ISSUE through DONE inclusive, and zero in IDLE.
REQ-023 In WAIT, the block SHALL capture in_MulOut into out_Result on the edge where in_MulReady=1, then move to DONE; in_MulReady SHALL be ignored in all other states.
REQ-024 In WAIT, a cycle counter SHALL increment each cycle; if it reaches TIMEOUT without in_MulReady, the block SHALL set out_Err, load out_Result=16'h0000 and move to DONE.
REQ-025 If in_MulReady=1 occurs on the same edge the counter reaches TIMEOUT, the block SHALL capture the product and SHALL NOT set out_Err.
REQ-026 In DONE, the block SHALL pulse out_Done[winner] for one cycle, set ptr=(winner+1) mod N_REQ, and return to IDLE.
REQ-027 out_Result SHALL hold its value until the next DONE.
REQ-028 Requester latency SHALL be k+3 cycles from the IDLE sampling edge to the out_Done pulse, where k is the number of WAIT cycles up to and including the in_MulReady edge.
REQ-029 A requester whose in_Req is still high in the IDLE cycle after its DONE SHALL be treated as a new request and SHALL lose priority to any other pending requester.
REQ-030 Deassertion of in_Req after the grant SHALL NOT abort the transaction; the transaction SHALL complete and out_Done SHALL still pulse.
REQ-031 out_Err SHALL be cleared only by rst.

Reset
REQ-032 While rst=1, irrespective of clk, the block SHALL hold state=IDLE, ptr=0, counter=0, out_Grant=0, out_Done=0, out_Result=0, out_MulA=0, out_MulB=0, out_MulEn=0, out_Busy=0 and out_Err=0.
REQ-033 Reset asserted mid-transaction SHALL abandon that transaction with no out_Done pulse; after release, requester 0 SHALL have highest priority.

Verification
REQ-034 Single request: in_Req=0001, A=B=16'h1000, with the multiplier model returning 16'h0100 after 2 WAIT cycles -> out_MulEn pulses once, out_Grant=0001, out_Done=0001 pulses, out_Result=16'h0100, latency 5 cycles.
REQ-035 All requesters pending: in_Req=1111 held -> grants served in order 0,1,2,3,0, each completing before the next out_MulEn.
REQ-036 Timeout: in_MulReady never asserted -> DONE entered after 16 WAIT cycles, out_Result=0, out_Err=1 and stays 1 after the next successful transaction.
REQ-037 Ready on the timeout edge: in_MulReady=1 on WAIT cycle 16 with product 16'h7FFF -> out_Result=16'h7FFF, out_Err=0.
REQ-038 Reset mid-WAIT: rst pulsed during WAIT -> all outputs zero immediately, no out_Done; afterwards, with in_Req=1010, requester 1 is served first.
REQ-039 Operand stability: in_A changed during WAIT -> out_MulA unchanged until DONE.
